// File: rtl/arb_merge_pkg.sv
// arb_merge_pkg
// Shared constants and arbitration helpers for arb_merge_n.
//   ARB_FIXED / ARB_RR : values of the ARB_MODE parameter.
//   MAX_CH             : widest request vector the helpers handle (NUM_CH <= 32).
//   lowest_set()       : index of the lowest set bit (0 when none are set).
//   rr_winner()        : first set bit at or above ptr, wrapping to bit 0.
package arb_merge_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int MAX_CH    = 32;

  function automatic int lowest_set(input logic [MAX_CH-1:0] req);
    int idx;
    idx = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = i;
    end
    return idx;
  endfunction

  // Requests below ptr are masked off first; if nothing remains at or above
  // ptr the search wraps around and takes the lowest request overall.
  function automatic int rr_winner(input logic [MAX_CH-1:0] req, input int ptr);
    logic [MAX_CH-1:0] upper;
    upper = req & ~((MAX_CH'(1) << ptr) - MAX_CH'(1));
    return (upper != '0) ? lowest_set(upper) : lowest_set(req);
  endfunction

endpackage

// File: rtl/arb_merge_n_if.sv
// arb_merge_n_if
// Handshake bundle of arb_merge_n: NUM_CH producer channels in, one merged
// stream out.
//   i_drive_n / i_data_n / o_free_n : per-channel valid, packed payload, ready
//   o_driveNext / o_data / i_freeNext : merged output valid, payload, ready
//   o_idle  : nothing buffered and no word on the output
//   o_srcId : source channel of o_data (only with ARB_MERGE_SRCID_EN)
// Modports: slave = the merge block, master = the producers/consumer side.
interface arb_merge_n_if #(
  parameter int NUM_CH     = 8,
  parameter int DATA_WIDTH = 12
);
  import arb_merge_pkg::*;

  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            i_drive_n;
  logic [NUM_CH*DATA_WIDTH-1:0] i_data_n;
  logic [NUM_CH-1:0]            o_free_n;
  logic                         o_driveNext;
  logic [DATA_WIDTH-1:0]        o_data;
  logic                         i_freeNext;
  logic                         o_idle;
`ifdef ARB_MERGE_SRCID_EN
  logic [ID_W-1:0]              o_srcId;

  modport slave  (input  i_drive_n, i_data_n, i_freeNext,
                  output o_free_n, o_driveNext, o_data, o_idle, o_srcId);
  modport master (output i_drive_n, i_data_n, i_freeNext,
                  input  o_free_n, o_driveNext, o_data, o_idle, o_srcId);
`else
  modport slave  (input  i_drive_n, i_data_n, i_freeNext,
                  output o_free_n, o_driveNext, o_data, o_idle);
  modport master (output i_drive_n, i_data_n, i_freeNext,
                  input  o_free_n, o_driveNext, o_data, o_idle);
`endif

endinterface

// File: rtl/sync_fifo_n.sv
// sync_fifo_n
// Single-clock FIFO with a combinational read port (head word always on rdata).
//   clk, rst     : clock, asynchronous active-high reset (pointers only)
//   push, wdata  : write request and data, ignored when full
//   pop          : advance past the head word, ignored when empty
//   rdata        : current head word (undefined when empty)
//   full, empty  : status from the registered pointers
// Pointers carry one wrap bit above the address: equal addresses with equal
// wrap bits means empty, with different wrap bits means full.
module sync_fifo_n
  import arb_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/arb_merge_n.sv
// arb_merge_n
// N-to-1 arbitrated merge: each producer channel feeds its own sync_fifo_n,
// and one non-empty FIFO per load is popped into a registered output stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : arb_merge_n_if.slave (channel inputs, merged output, o_idle)
// Parameters: NUM_CH (2..32), DATA_WIDTH, FIFO_DEPTH (power of two, >= 2),
// ARB_MODE (ARB_FIXED: lowest index wins, ARB_RR: rotating pointer).
// Optional: ARB_MERGE_SRCID_EN stores the channel index with each FIFO entry
// and presents it on o_srcId alongside o_data.
module arb_merge_n
  import arb_merge_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_MODE   = ARB_FIXED
) (
  input logic         clk,
  input logic         rst,
  arb_merge_n_if.slave bus
);

  localparam int ID_W = $clog2(NUM_CH);
`ifdef ARB_MERGE_SRCID_EN
  localparam int ENTRY_W = DATA_WIDTH + ID_W;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     empty;
  logic [NUM_CH-1:0]     free;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;
  logic [NUM_CH-1:0]     req;
  logic [ENTRY_W-1:0]    rd_entry [NUM_CH];

  logic                  rdy_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       win_idx;
  logic                  drive_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  any_req;
  logic                  load;
  logic                  grant;

  // Holds every o_free_n low while rst is asserted; the FIFOs come out of
  // reset empty, so without this the channels would look ready during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  // Readiness comes only from the registered count, so a full FIFO refuses a
  // push even in the cycle it is being popped.
  assign free         = ~full & {NUM_CH{rdy_q}};
  assign push         = bus.i_drive_n & free;
  assign bus.o_free_n = free;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ENTRY_W-1:0] wr_entry;
`ifdef ARB_MERGE_SRCID_EN
    assign wr_entry = {ID_W'(k), bus.i_data_n[k*DATA_WIDTH +: DATA_WIDTH]};
`else
    assign wr_entry = bus.i_data_n[k*DATA_WIDTH +: DATA_WIDTH];
`endif

    sync_fifo_n #(
      .DATA_WIDTH (ENTRY_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .wdata (wr_entry),
      .rdata (rd_entry[k]),
      .full  (full[k]),
      .empty (empty[k])
    );

    assign pop[k] = grant && (win_idx == ID_W'(k));
  end

  assign req     = ~empty;
  assign any_req = |req;
  // The output stage accepts a new word when it is empty or being drained.
  assign load    = ~drive_q | bus.i_freeNext;
  assign grant   = load & any_req;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    win_idx = '0;
    if (ARB_MODE == ARB_RR) win_idx = ID_W'(rr_winner(MAX_CH'(req), int'(ptr_q)));
    else                    win_idx = ID_W'(lowest_set(MAX_CH'(req)));
  end

`ifdef ARB_MERGE_SRCID_EN
  logic [ID_W-1:0] id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        id_q <= '0;
    else if (grant) id_q <= rd_entry[win_idx][ENTRY_W-1:DATA_WIDTH];
  end

  assign bus.o_srcId = id_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_q <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      // A load with nothing to grant empties the output; o_data keeps its value.
      if (load) drive_q <= any_req;
      if (grant) begin
        data_q <= rd_entry[win_idx][DATA_WIDTH-1:0];
        if (ARB_MODE == ARB_RR) begin
          ptr_q <= (win_idx == ID_W'(NUM_CH - 1)) ? '0 : win_idx + ID_W'(1);
        end
      end
    end
  end

  assign bus.o_driveNext = drive_q;
  assign bus.o_data      = data_q;
  assign bus.o_idle      = ~drive_q & (&empty);

endmodule

// File: tb/tb_arb_merge_n.sv
// tb_arb_merge_n
// Directed bench for arb_merge_n with two instances sharing clk/rst:
// u_fix (fixed priority) and u_rr (round-robin). Expected output words are
// queued as stimulus is applied and matched against every output transfer.
// With ARB_MERGE_SRCID_EN defined the source channel is compared as well.
module tb_arb_merge_n;
  import arb_merge_pkg::*;

  localparam int NUM_CH = 8;
  localparam int DW     = 12;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;

  arb_merge_n_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus_f ();
  arb_merge_n_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus_r ();

  arb_merge_n #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_FIXED)) u_fix (
    .clk (clk),
    .rst (rst),
    .bus (bus_f.slave)
  );

  arb_merge_n #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_RR)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_r.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_f [$];   // {channel, payload} in expected output order
  logic [15:0] exp_r [$];
  int   m_cnt;              // channel-0 occupancy model for u_fix
  logic m_out;              // u_fix output-register occupancy model

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_f(input int ch, input logic [DW-1:0] val);
    bus_f.i_data_n[ch*DW +: DW] = val;
  endtask

  task automatic drive_r(input int ch, input logic [DW-1:0] val);
    bus_r.i_data_n[ch*DW +: DW] = val;
  endtask

  // One clock: note which outputs transfer at the coming edge, then score them.
  task automatic tick();
    logic xf_f, xf_r;
    logic [DW-1:0] d_f, d_r;
    logic [3:0] id_f, id_r;
    logic [15:0] e;
    xf_f = bus_f.o_driveNext & bus_f.i_freeNext;
    xf_r = bus_r.o_driveNext & bus_r.i_freeNext;
    d_f  = bus_f.o_data;
    d_r  = bus_r.o_data;
    id_f = '0;
    id_r = '0;
`ifdef ARB_MERGE_SRCID_EN
    id_f = 4'(bus_f.o_srcId);
    id_r = 4'(bus_r.o_srcId);
`endif
    @(posedge clk);
    #1;
    if (xf_f) begin
      n_vec++;
      assert (exp_f.size() != 0) else begin
        n_err++;
        $error("FAIL fix_spurious: observed word %0h expected none", d_f);
      end
      if (exp_f.size() != 0) begin
        e = exp_f.pop_front();
        check("fix_data", 32'(d_f), 32'(e[11:0]));
`ifdef ARB_MERGE_SRCID_EN
        check("fix_srcid", 32'(id_f), 32'(e[15:12]));
`endif
      end
    end
    if (xf_r) begin
      n_vec++;
      assert (exp_r.size() != 0) else begin
        n_err++;
        $error("FAIL rr_spurious: observed word %0h expected none", d_r);
      end
      if (exp_r.size() != 0) begin
        e = exp_r.pop_front();
        check("rr_data", 32'(d_r), 32'(e[11:0]));
`ifdef ARB_MERGE_SRCID_EN
        check("rr_srcid", 32'(id_r), 32'(e[15:12]));
`endif
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(exp_f.size() == 0 && exp_r.size() == 0 && bus_f.o_idle && bus_r.o_idle) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(n < 100), 32'd1);
  endtask

  // Channel-0 cycle on u_fix with an independent occupancy model deciding
  // readiness and which pushes are accepted.
  task automatic chan0_cycle(input logic drv, input logic fr, input logic [DW-1:0] val);
    logic exp_free, pushed, ld, popped;
    bus_f.i_freeNext  = fr;
    bus_f.i_drive_n   = {7'b0, drv};
    bus_f.i_data_n[DW-1:0] = val;
    exp_free = (m_cnt != DEPTH);
    check("free0", 32'(bus_f.o_free_n[0]), 32'(exp_free));
    pushed = drv & exp_free;
    if (pushed) exp_f.push_back({4'd0, val});
    ld     = !m_out || fr;
    popped = ld && (m_cnt != 0);
    if (ld) m_out = (m_cnt != 0);
    m_cnt = m_cnt + int'(pushed) - int'(popped);
    tick();
  endtask

  initial begin
    rst              = 1'b1;
    bus_f.i_drive_n  = '0;
    bus_f.i_data_n   = '0;
    bus_f.i_freeNext = 1'b1;
    bus_r.i_drive_n  = '0;
    bus_r.i_data_n   = '0;
    bus_r.i_freeNext = 1'b1;
    m_cnt = 0;
    m_out = 1'b0;

    // Reset state
    #3;
    check("rst_valid", 32'(bus_f.o_driveNext), 32'd0);
    check("rst_data",  32'(bus_f.o_data), 32'd0);
    check("rst_idle",  32'(bus_f.o_idle), 32'd1);
    check("rst_free",  32'(bus_f.o_free_n), 32'h00);
    check("rst_free_rr", 32'(bus_r.o_free_n), 32'h00);
`ifdef ARB_MERGE_SRCID_EN
    check("rst_srcid", 32'(bus_f.o_srcId), 32'd0);
`endif
    #10 rst = 1'b0;
    tick();
    check("free_after_rst", 32'(bus_f.o_free_n), 32'hFF);

    // Single channel: 0x5A5 on channel 3, one cycle acceptance-to-output
    bus_f.i_drive_n = 8'h08;
    drive_f(3, 12'h5A5);
    exp_f.push_back({4'd3, 12'h5A5});
    tick();
    bus_f.i_drive_n = '0;
    check("lat_valid_e0", 32'(bus_f.o_driveNext), 32'd0);
    tick();
    check("lat_valid", 32'(bus_f.o_driveNext), 32'd1);
    check("lat_data",  32'(bus_f.o_data), 32'h5A5);
`ifdef ARB_MERGE_SRCID_EN
    check("lat_srcid", 32'(bus_f.o_srcId), 32'd3);
`endif
    drain("single");
    check("idle_after_single", 32'(bus_f.o_idle), 32'd1);

    // Fixed priority: channels 1 and 6 with two words each -> 1,1,6,6
    exp_f.push_back({4'd1, 12'h101});
    exp_f.push_back({4'd1, 12'h102});
    exp_f.push_back({4'd6, 12'h601});
    exp_f.push_back({4'd6, 12'h602});
    bus_f.i_drive_n = 8'h42;
    drive_f(1, 12'h101);
    drive_f(6, 12'h601);
    tick();
    drive_f(1, 12'h102);
    drive_f(6, 12'h602);
    tick();
    bus_f.i_drive_n = '0;
    drain("fixed");

    // Round-robin: all channels hold two words -> 0..7, 0..7 (ptr wraps 7->0)
    for (int r = 0; r < 2; r++) begin
      for (int ch = 0; ch < NUM_CH; ch++) exp_r.push_back({4'(ch), 12'h800 + 12'(ch*16 + r)});
    end
    bus_r.i_drive_n = 8'hFF;
    for (int ch = 0; ch < NUM_CH; ch++) drive_r(ch, 12'h800 + 12'(ch*16));
    tick();
    for (int ch = 0; ch < NUM_CH; ch++) drive_r(ch, 12'h800 + 12'(ch*16 + 1));
    tick();
    bus_r.i_drive_n = '0;
    drain("rr_all");

    // Round-robin pointer follows the last winner: grant 5, then 6 beats 2
    exp_r.push_back({4'd5, 12'h555});
    bus_r.i_drive_n = 8'h20;
    drive_r(5, 12'h555);
    tick();
    bus_r.i_drive_n = '0;
    drain("rr_ptr_set");
    exp_r.push_back({4'd6, 12'h666});
    exp_r.push_back({4'd2, 12'h222});
    bus_r.i_drive_n = 8'h44;
    drive_r(2, 12'h222);
    drive_r(6, 12'h666);
    tick();
    bus_r.i_drive_n = '0;
    drain("rr_ptr_use");

    // Backpressure: downstream stalled 10 cycles, channel 0 driven each cycle
    m_cnt = 0;
    m_out = 1'b0;
    for (int i = 0; i < 10; i++) chan0_cycle(1'b1, 1'b0, 12'h700 + 12'(i));
    check("bp_data_frozen", 32'(bus_f.o_data), 32'h700);
    check("bp_valid",       32'(bus_f.o_driveNext), 32'd1);
    check("bp_free0_low",   32'(bus_f.o_free_n[0]), 32'd0);
    chan0_cycle(1'b0, 1'b1, 12'h000);
    bus_f.i_drive_n = '0;
    drain("bp");

    // Full-and-pop: a full FIFO refuses the push in its pop cycle, takes it next
    m_cnt = 0;
    m_out = 1'b0;
    for (int i = 0; i < 6; i++) chan0_cycle(1'b1, 1'b0, 12'h900 + 12'(i));
    chan0_cycle(1'b1, 1'b1, 12'h910);
    chan0_cycle(1'b1, 1'b0, 12'h911);
    chan0_cycle(1'b0, 1'b0, 12'h000);
    bus_f.i_freeNext = 1'b1;
    drain("full_pop");

    // Reset mid-stream with words queued on channel 2: everything discarded
    bus_f.i_freeNext = 1'b0;
    bus_f.i_drive_n  = 8'h04;
    for (int i = 0; i < 4; i++) begin
      drive_f(2, 12'h2A0 + 12'(i));
      tick();
    end
    bus_f.i_drive_n = '0;
    check("pre_rst_valid", 32'(bus_f.o_driveNext), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus_f.o_driveNext), 32'd0);
    check("mid_rst_data",  32'(bus_f.o_data), 32'd0);
    check("mid_rst_idle",  32'(bus_f.o_idle), 32'd1);
    check("mid_rst_free",  32'(bus_f.o_free_n), 32'h00);
    tick();
    tick();
    rst = 1'b0;
    bus_f.i_freeNext = 1'b1;
    repeat (8) tick();
    check("post_rst_valid", 32'(bus_f.o_driveNext), 32'd0);
    check("post_rst_idle",  32'(bus_f.o_idle), 32'd1);
    check("post_rst_free",  32'(bus_f.o_free_n), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb_merge_n.md
# arb_merge_n

Synchronous, parametrised N-to-1 arbitrated merge: NUM_CH producer channels, each buffered in its own FIFO, are merged onto a single output stream under fixed-priority or round-robin arbitration. Clocked successor to the eight-input click-based merge, for the single-clock datapath between the matrix tile producers and the shared result writer. Uses the same drive/free handshake naming, and adds configurable channel count, per-channel depth, fairness mode and an idle indicator.

## Interface
- NUM_CH, 8: number of input channels, 2..32.
- DATA_WIDTH, 12: payload width.
- FIFO_DEPTH, 4: entries per channel FIFO, power of two, ≥2.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_drive_n  in  NUM_CH  per-channel valid.
- i_data_n  in  NUM_CH*DATA_WIDTH  packed payloads, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_free_n  out  NUM_CH  per-channel ready (FIFO not full).
- o_driveNext  out  1  output valid.
- o_data  out  DATA_WIDTH  output payload (registered).
- i_freeNext  in  1  downstream ready.
- o_idle  out  1  all FIFOs and output register empty.
- o_srcId  out  $clog2(NUM_CH)  source channel of o_data (only with ARB_MERGE_SRCID_EN).

## Operation
- Channel push: i_drive_n[k] & o_free_n[k] at a rising edge writes i_data_n slice k into FIFO k. i_drive_n[k] without o_free_n[k]: no write; producer holds data.
- Requests: req[k] = FIFO k non-empty. Output register loads (load = ~o_driveNext | i_freeNext) when any req: winner popped, payload to o_data, o_driveNext set. Load with no req and i_freeNext: o_driveNext cleared, o_data holds.
- Fixed priority: winner = lowest-index req.
- Round-robin: pointer ptr (0..NUM_CH-1); winner = first req at index ≥ptr, wrapping to 0. On each load with a grant, ptr ← winner+1, wrapping NUM_CH-1 → 0. ptr unchanged when no grant.
- Output handshake: word transferred when o_driveNext & i_freeNext. o_data/o_srcId stable while o_driveNext & ~i_freeNext.
- Push and pop of the same FIFO in one cycle: both happen, count unchanged. o_free_n is derived from the registered count only: a full FIFO refuses pushes even when it is being popped in that cycle.
- o_idle = ~o_driveNext & no FIFO holds data.

## Timing
- Reset (rst high, async): FIFOs empty, ptr=0, o_driveNext=0, o_data=0, o_srcId=0, o_idle=1, o_free_n all 0. o_free_n all 1 from the first cycle after rst deasserts.
- Latency: word accepted at edge E0 → visible on o_driveNext/o_data after edge E1 (if arbitration is won and the output is free) → 1 cycle acceptance-to-output.
- Throughput: 1 word/cycle aggregate with i_freeNext held high. Per channel: 1 word/cycle when it is the sole requester.
- Reset mid-operation: all buffered and in-flight words discarded, with no partial transfer.
- FIFO wrap: read/write pointers are log2(FIFO_DEPTH) bits with an extra wrap bit. Full = addresses equal and wrap bits differ.

## Configuration
- ARB_MERGE_SRCID_EN defined: each FIFO entry stores its channel index alongside the payload. o_srcId is present and registered with o_data.
- Undefined: the o_srcId port and its storage are absent. Merge behaviour is otherwise identical.

## Structure
- Package arb_merge_pkg holds: ARB_FIXED=0 / ARB_RR=1 constants; a function returning the round-robin winner index from req and ptr; a function returning the lowest-set-bit index.
- One sub-module, sync_fifo_n (DATA_WIDTH, FIFO_DEPTH; push/pop/full/empty), instantiated NUM_CH times in a generate loop. Arbiter and output register sit inline in the top.

## Test plan
- Reset: assert rst mid-stream with 3 words queued on channel 2 → o_driveNext=0, o_data=0, o_idle=1 immediately; no stale word appears after release.
- Single channel: drive 0x5A5 on channel 3 at cycle 0 with i_freeNext=1 → o_data=0x5A5 and o_driveNext=1 in cycle 1; o_srcId=3 with the macro defined.
- Fixed priority (ARB_MODE=0): channels 1 and 6 each hold 2 words → order 1,1,6,6.
- Round-robin (ARB_MODE=1): all 8 channels hold 2 words each, ptr=0 → order 0..7,0..7; ptr wraps 7→0.
- Backpressure: i_freeNext=0 for 10 cycles with FIFO_DEPTH=4 and channel 0 driven each cycle → o_data frozen; o_free_n[0]=0 after 4 accepted words beyond the output register; no loss or duplication after release.
- Full-and-pop: channel 0 full, i_freeNext=1, i_drive_n[0]=1 → push refused that cycle, accepted the next cycle, count returns to 4.
